// File: rtl/crtc_pkg.sv
// -----------------------------------------------------------------------------
// crtc_pkg
// Shared definitions for the CRTC timing chain.
//   crtc_state_t     - per-axis line state (ACTIVE, FRONT, SYNC, BACK)
//   H_* constants    - 640x480 horizontal timing, used as the DEF_* defaults
//   V_* constants    - 640x480 vertical timing, for the vertical instance
//   crtc_next_state  - prioritised state transition used by crtc_line_timing
// -----------------------------------------------------------------------------
package crtc_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } crtc_state_t;

    // 640x480 horizontal: 640 active, 16 front porch, 96 sync, 48 back porch.
    localparam int H_FP_START   = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int H_TOTAL      = 799;

    // 640x480 vertical: 480 active, 10 front porch, 2 sync, 33 back porch.
    localparam int V_FP_START   = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;
    localparam int V_TOTAL      = 524;

    // Transition rules in priority order. A rule whose source state does not
    // match falls through to the lower-priority rules, so e.g. a sync-end
    // match outside SYNC never blocks a sync-start match on the same count.
    // The count==0 rule wins from any state, which is what pulls an illegally
    // programmed axis back to ACTIVE at the start of every line.
    function automatic crtc_state_t crtc_next_state(
        input crtc_state_t cur,
        input logic        at_zero,
        input logic        at_send,
        input logic        at_sync,
        input logic        at_fp
    );
        crtc_state_t nxt;
        nxt = cur;
        if (at_zero)
            nxt = ST_ACTIVE;
        else if (at_send && (cur == ST_SYNC))
            nxt = ST_BACK;
        else if (at_sync && ((cur == ST_ACTIVE) || (cur == ST_FRONT)))
            nxt = ST_SYNC;
        else if (at_fp && (cur == ST_ACTIVE))
            nxt = ST_FRONT;
        return nxt;
    endfunction

endpackage

// File: rtl/crtc_line_timing.sv
// -----------------------------------------------------------------------------
// crtc_line_timing
// Timing decode for one CRTC axis. Sits after a loadable up-counter, decodes
// its count into sync / blank / line_end, and drives the counter's load/value
// so the count runs 0..total and wraps.
//
// Ports
//   clk         clock
//   reset       asynchronous, active-high reset
//   count       current count from the up-counter
//   fp_start    programmed first non-active count
//   sync_start  programmed first sync count
//   sync_end    programmed first count after sync
//   total       programmed last count of the line
//   load        to counter load (combinational, high on the last count)
//   value       to counter value (constant 0)
//   sync        sync pulse at SYNC_ACTIVE level (registered)
//   blank       1 outside the active region (registered)
//   line_end    one-clock pulse per line, coincident with count 0 (registered)
//
// sync and blank lag count by one clock: the outputs in cycle t+1 describe
// the count sampled in cycle t.
// -----------------------------------------------------------------------------
module crtc_line_timing
    import crtc_pkg::*;
#(
    parameter int WIDTH          = 11,
    parameter bit SYNC_ACTIVE    = 1'b0,
    parameter int DEF_FP_START   = H_FP_START,
    parameter int DEF_SYNC_START = H_SYNC_START,
    parameter int DEF_SYNC_END   = H_SYNC_END,
    parameter int DEF_TOTAL      = H_TOTAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] fp_start,
    input  logic [WIDTH-1:0] sync_start,
    input  logic [WIDTH-1:0] sync_end,
    input  logic [WIDTH-1:0] total,
    output logic             load,
    output logic [WIDTH-1:0] value,
    output logic             sync,
    output logic             blank,
    output logic             line_end
);

    // Shadow copies of the programmed timing; only updated at the wrap so a
    // line is always decoded against one consistent set of values.
    logic [WIDTH-1:0] fp_sh;
    logic [WIDTH-1:0] sync_sh;
    logic [WIDTH-1:0] send_sh;
    logic [WIDTH-1:0] tot_sh;

    logic        at_total;
    crtc_state_t state;
    crtc_state_t state_nxt;

    assign at_total = (count == tot_sh);

    // Must stay combinational: the counter reloads on the same edge it shows
    // tot_sh, giving exactly tot_sh+1 counts per line.
    assign load  = at_total;
    assign value = '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fp_sh   <= WIDTH'(DEF_FP_START);
            sync_sh <= WIDTH'(DEF_SYNC_START);
            send_sh <= WIDTH'(DEF_SYNC_END);
            tot_sh  <= WIDTH'(DEF_TOTAL);
        end else if (at_total) begin
            fp_sh   <= fp_start;
            sync_sh <= sync_start;
            send_sh <= sync_end;
            tot_sh  <= total;
        end
    end

    always_comb begin
        state_nxt = crtc_next_state(state,
                                    count == '0,
                                    count == send_sh,
                                    count == sync_sh,
                                    count == fp_sh);
    end

    // State and its decoded outputs are registered together so blank/sync
    // come straight from flops and cannot glitch on a state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_BACK;
            blank    <= 1'b1;
            sync     <= ~SYNC_ACTIVE;
            line_end <= 1'b0;
        end else begin
            state    <= state_nxt;
            blank    <= (state_nxt != ST_ACTIVE);
            sync     <= (state_nxt == ST_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            line_end <= at_total;
        end
    end

endmodule

// File: tb/tb_crtc_line_timing.sv
// -----------------------------------------------------------------------------
// tb_crtc_line_timing
// Closed-loop bench: a loadable up-counter feeds two crtc_line_timing
// instances (active-low and active-high sync) sharing one count. A reference
// model derives the expected outputs from the timing regions of each line.
// -----------------------------------------------------------------------------
module tb_crtc_line_timing;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] count;
    logic [W-1:0] fp_start, sync_start, sync_end, total;
    logic         load, sync, blank, line_end;
    logic [W-1:0] value;
    logic         load_hi, sync_hi, blank_hi, line_end_hi;
    logic [W-1:0] value_hi;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    crtc_line_timing #(
        .WIDTH(W), .SYNC_ACTIVE(1'b0),
        .DEF_FP_START(8), .DEF_SYNC_START(10), .DEF_SYNC_END(12), .DEF_TOTAL(15)
    ) u_dut (
        .clk(clk), .reset(reset), .count(count),
        .fp_start(fp_start), .sync_start(sync_start), .sync_end(sync_end), .total(total),
        .load(load), .value(value), .sync(sync), .blank(blank), .line_end(line_end)
    );

    crtc_line_timing #(
        .WIDTH(W), .SYNC_ACTIVE(1'b1),
        .DEF_FP_START(8), .DEF_SYNC_START(10), .DEF_SYNC_END(12), .DEF_TOTAL(15)
    ) u_dut_hi (
        .clk(clk), .reset(reset), .count(count),
        .fp_start(fp_start), .sync_start(sync_start), .sync_end(sync_end), .total(total),
        .load(load_hi), .value(value_hi), .sync(sync_hi), .blank(blank_hi), .line_end(line_end_hi)
    );

    // Loadable up-counter closing the loop through the active-low instance.
    always @(posedge clk or posedge reset) begin
        if (reset)     count <= '0;
        else if (load) count <= value;
        else           count <= count + 1'b1;
    end

    // Reference model: a line is 0..tot; blank covers [fp, tot], sync covers
    // [sy, se) (or [sy, tot] when se <= sy, since only count 0 ends it).
    // Each output describes the count seen on the previous edge.
    logic [W-1:0] m_fp, m_sy, m_se, m_tot;
    logic         exp_blank, exp_sync_on, exp_le;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fp <= 8'd8; m_sy <= 8'd10; m_se <= 8'd12; m_tot <= 8'd15;
            exp_blank <= 1'b1; exp_sync_on <= 1'b0; exp_le <= 1'b0;
        end else begin
            exp_blank   <= (count >= m_fp);
            exp_sync_on <= (count >= m_sy) && ((m_se <= m_sy) || (count < m_se));
            exp_le      <= (count == m_tot);
            if (count == m_tot) begin
                m_fp <= fp_start; m_sy <= sync_start; m_se <= sync_end; m_tot <= total;
            end
        end
    end

    // Cycle-by-cycle scoreboard against the model, sampled 2 units after the edge.
    always @(posedge clk) begin
        #2;
        n_checks++;
        if (blank !== exp_blank || blank_hi !== exp_blank) begin
            n_fail++;
            $display("FAIL mon_blank t=%0t count=%0d got %b/%b want %b", $time, count, blank, blank_hi, exp_blank);
        end
        n_checks++;
        if (sync !== ~exp_sync_on || sync_hi !== exp_sync_on) begin
            n_fail++;
            $display("FAIL mon_sync t=%0t count=%0d got lo=%b hi=%b want lo=%b hi=%b", $time, count, sync, sync_hi, ~exp_sync_on, exp_sync_on);
        end
        n_checks++;
        if (line_end !== exp_le || line_end_hi !== exp_le) begin
            n_fail++;
            $display("FAIL mon_line_end t=%0t count=%0d got %b/%b want %b", $time, count, line_end, line_end_hi, exp_le);
        end
        n_checks++;
        if (load !== (count == m_tot) || load_hi !== (count == m_tot) || value !== '0 || value_hi !== '0) begin
            n_fail++;
            $display("FAIL mon_load t=%0t count=%0d got load=%b value=%0d want load=%b value=0", $time, count, load, value, (count == m_tot));
        end
    end

    task automatic set_cfg(input int f, input int s, input int e, input int t);
        fp_start = W'(f); sync_start = W'(s); sync_end = W'(e); total = W'(t);
    endtask

    // Advance to the sample where count == v (bounded).
    task automatic wait_count(input int v, input string tag);
        bit hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clk); #2;
            if (count == W'(v)) hit = 1;
        end
        if (!hit) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: count never reached %0d", tag, v);
        end
    endtask

    // Advance to the next line_end sample; returns the number of samples taken.
    task automatic wait_le(input string tag, output int cyc);
        bit hit = 0;
        cyc = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clk); #2;
            cyc++;
            if (line_end) hit = 1;
        end
        if (!hit) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no line_end within 400 clocks", tag);
        end
    endtask

    task automatic test_reset;
        set_cfg(8, 10, 12, 15);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (blank !== 1'b1 || sync !== 1'b1 || sync_hi !== 1'b0 || line_end !== 1'b0 ||
            load !== 1'b0 || value !== '0 || count !== '0) begin
            n_fail++;
            $display("FAIL reset_state got blank=%b sync=%b sync_hi=%b le=%b load=%b value=%0d want 1 1 0 0 0 0",
                     blank, sync, sync_hi, line_end, load, value);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (blank !== 1'b0 || count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_first_edge got blank=%b count=%0d want blank=0 count=1", blank, count);
        end
    endtask

    task automatic test_steady;
        int c, le_n = 0, ld_n = 0;
        set_cfg(8, 10, 12, 15);
        wait_le("steady", c);
        for (int i = 0; i < 48; i++) begin
            @(posedge clk); #2;
            if (line_end) le_n++;
            if (load) ld_n++;
            if (count == 8'd8 || count == 8'd9) begin
                n_checks++;
                if (blank !== (count == 8'd9)) begin
                    n_fail++;
                    $display("FAIL steady_blank count=%0d got %b want %b", count, blank, (count == 8'd9));
                end
            end
            if (count == 8'd11 || count == 8'd13) begin
                n_checks++;
                if (sync !== (count == 8'd13)) begin
                    n_fail++;
                    $display("FAIL steady_sync count=%0d got %b want %b", count, sync, (count == 8'd13));
                end
            end
        end
        n_checks++;
        if (le_n != 3 || ld_n != 3) begin
            n_fail++;
            $display("FAIL steady_counts got line_end=%0d load=%0d want 3 3", le_n, ld_n);
        end
    endtask

    task automatic test_zero_fp;
        int c, k_blank = -1, k_sync = -1;
        set_cfg(10, 10, 12, 15);
        wait_le("zero_fp", c);
        wait_le("zero_fp", c);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #2;
            if (blank && k_blank < 0) k_blank = k;
            if (!sync && k_sync < 0) k_sync = k;
        end
        n_checks++;
        if (k_blank != 11 || k_sync != 11) begin
            n_fail++;
            $display("FAIL zero_fp_edges got blank@%0d sync@%0d want 11 11", k_blank, k_sync);
        end
        set_cfg(8, 10, 12, 15);
        wait_le("zero_fp", c);
    endtask

    task automatic test_reprogram;
        int c1, c2, c3;
        set_cfg(8, 10, 12, 15);
        wait_le("reprog", c1);
        wait_count(5, "reprog");
        set_cfg(8, 10, 12, 19);
        wait_le("reprog", c1);
        wait_le("reprog", c2);
        set_cfg(8, 10, 12, 15);
        wait_le("reprog", c3);
        n_checks++;
        if (c1 != 11 || c2 != 20 || c3 != 20) begin
            n_fail++;
            $display("FAIL reprog_period got %0d/%0d/%0d want 11/20/20", c1, c2, c3);
        end
        wait_le("reprog", c1);
        n_checks++;
        if (c1 != 16) begin
            n_fail++;
            $display("FAIL reprog_restore got period %0d want 16", c1);
        end
    endtask

    task automatic test_reset_mid_sync;
        int c1, c2;
        set_cfg(8, 10, 12, 15);
        wait_le("rst_sync", c1);
        wait_count(11, "rst_sync");
        n_checks++;
        if (sync !== 1'b0 || sync_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_sync_pre got sync=%b sync_hi=%b want 0 1", sync, sync_hi);
        end
        @(negedge clk) reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (blank !== 1'b1 || sync !== 1'b1 || sync_hi !== 1'b0 || line_end !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_sync_hold[%0d] got blank=%b sync=%b sync_hi=%b le=%b want 1 1 0 0",
                         i, blank, sync, sync_hi, line_end);
            end
            @(posedge clk); #2;
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (blank !== 1'b0 || count !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_sync_release got blank=%b count=%0d want 0 1", blank, count);
        end
        wait_le("rst_sync", c1);
        wait_le("rst_sync", c2);
        n_checks++;
        if (c1 != 15 || c2 != 16) begin
            n_fail++;
            $display("FAIL rst_sync_line got %0d/%0d want 15/16", c1, c2);
        end
    endtask

    task automatic test_illegal;
        int c;
        set_cfg(8, 10, 9, 15);
        wait_le("illegal", c);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #2;
            if (count >= 8'd11 || count == 8'd0) begin
                n_checks++;
                if (sync !== 1'b0) begin
                    n_fail++;
                    $display("FAIL illegal_sync_held count=%0d got %b want 0", count, sync);
                end
            end else if (count == 8'd1) begin
                n_checks++;
                if (sync !== 1'b1 || blank !== 1'b0) begin
                    n_fail++;
                    $display("FAIL illegal_recover got sync=%b blank=%b want 1 0", sync, blank);
                end
            end
        end
        set_cfg(8, 10, 12, 15);
        wait_le("illegal", c);
        wait_le("illegal", c);
        n_checks++;
        if (c != 16) begin
            n_fail++;
            $display("FAIL illegal_no_hang got period %0d want 16", c);
        end
    endtask

    task automatic test_random;
        int f, s, e, t, n;
        for (int it = 0; it < 14; it++) begin
            f = $urandom_range(1, 20);
            s = f + $urandom_range(0, 5);
            e = s + $urandom_range(1, 6);
            t = e + $urandom_range(0, 6);
            set_cfg(f, s, e, t);
            n = $urandom_range(10, 70);
            for (int i = 0; i < n; i++) begin
                @(posedge clk); #2;
                if (line_end) begin
                    n_checks++;
                    if (count !== '0) begin
                        n_fail++;
                        $display("FAIL rand_le_at_zero got count=%0d want 0", count);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_zero_fp();
        test_reprogram();
        test_reset_mid_sync();
        test_illegal();
        test_random();
        @(posedge clk); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
